pipe_stage_ctrl: RTL and testbench

//  Consumer end of the 6-bit stall vector (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).

---
 rtl/pipe_pkg.sv | 17 +
 rtl/stage_valid_reg.sv | 29 ++
 rtl/pipe_stage_ctrl.sv | 93 +++++++++
 tb/tb_pipe_stage_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stage indices and stall-vector legality.
package pipe_pkg;

  localparam int STG_PC = 0;
  localparam int STG_IF = 1;
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB = 5;
  localparam int NUM_STAGES = 6;

  // Thermometer codes are a run of ones starting at bit 0.
  function automatic logic is_thermo(logic [5:0] v);
    return ((v + 6'd1) & v) == 6'd0;
  endfunction

endpackage

// File: rtl/stage_valid_reg.sv
// One pipeline register's valid bit plus its hold/advance/bubble decode.
module stage_valid_reg (
  input  logic clk,
  input  logic reset_n,
  input  logic up,
  input  logic dn,
  input  logic kill,
  input  logic vin,
  output logic adv,
  output logic bubble,
  output logic valid
);

  assign adv = ~up;
  assign bubble = up & ~dn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= vin;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush consumer: per-register enables, valid tracking, retire and health flags.
// STALL_PERF_CNT_EN adds stall_cyc_cnt and bubble_cnt outputs.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_STALL = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             pc_en,
  output logic [4:0]       reg_adv,
  output logic [4:0]       reg_bubble,
  output logic [4:0]       stage_valid,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             stall_err,
  output logic             stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cyc_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam logic [7:0] MAX_C = 8'(MAX_STALL);
  // Flush squashes R1..R3 only; MEM/WB contents are already committed.
  localparam logic [4:0] KILL = 5'b00111;

  logic [4:0] vin;
  logic [7:0] run;
  logic       ret_nx;

  assign pc_en = ~stall[STG_PC];
  assign vin = {stage_valid[3:0], fetch_valid};
  assign ret_nx = stage_valid[4] & ~stall[STG_WB];

  for (genvar k = 0; k < NUM_STAGES - 1; k++) begin : g_reg
    stage_valid_reg u_reg (
      .clk    (clk),
      .reset_n(reset_n),
      .up     (stall[k]),
      .dn     (stall[k+1]),
      .kill   (flush & KILL[k]),
      .vin    (vin[k]),
      .adv    (reg_adv[k]),
      .bubble (reg_bubble[k]),
      .valid  (stage_valid[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire <= 1'b0;
      retire_cnt <= '0;
    end else begin
      retire <= ret_nx;
      retire_cnt <= retire_cnt + CNT_W'(ret_nx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_err <= 1'b0;
      stall_timeout <= 1'b0;
      run <= '0;
    end else begin
      if (!is_thermo(stall)) stall_err <= 1'b1;
      if (stall[STG_PC]) begin
        if (run != MAX_C) run <= run + 8'd1;
        if (run == MAX_C - 8'd1) stall_timeout <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cyc_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cyc_cnt <= stall_cyc_cnt + CNT_W'(stall[STG_PC]);
      bubble_cnt <= bubble_cnt + CNT_W'(|reg_bubble);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized bench for pipe_stage_ctrl against a rule-level reference model.
module tb_pipe_stage_ctrl;

  localparam int MAXS = 4;
  localparam int CW = 4;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [5:0]    stall;
  logic          flush;
  logic          fetch_valid;
  logic          pc_en;
  logic [4:0]    reg_adv;
  logic [4:0]    reg_bubble;
  logic [4:0]    stage_valid;
  logic          retire;
  logic [CW-1:0] retire_cnt;
  logic          stall_err;
  logic          stall_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [CW-1:0] stall_cyc_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  pipe_stage_ctrl #(.MAX_STALL(MAXS), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .pc_en        (pc_en),
    .reg_adv      (reg_adv),
    .reg_bubble   (reg_bubble),
    .stage_valid  (stage_valid),
    .retire       (retire),
    .retire_cnt   (retire_cnt),
    .stall_err    (stall_err),
    .stall_timeout(stall_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cyc_cnt(stall_cyc_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit mv[1:5];
  bit mret, merr, mto;
  int mcnt, run, mcyc, mbub;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_adv();
    logic [4:0] a;
    for (int k = 1; k <= 5; k++) a[k-1] = !stall[k-1];
    return a;
  endfunction

  function automatic logic [4:0] exp_bub();
    logic [4:0] b;
    for (int k = 1; k <= 5; k++) b[k-1] = stall[k-1] && !stall[k];
    return b;
  endfunction

  function automatic logic [4:0] mvec();
    logic [4:0] v;
    for (int k = 1; k <= 5; k++) v[k-1] = mv[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 5; k++) mv[k] = 0;
    mret = 0; merr = 0; mto = 0;
    mcnt = 0; run = 0; mcyc = 0; mbub = 0;
  endtask

  task automatic model_edge();
    bit nv[1:5];
    bit prev;
    int c;
    int legal;
    for (int k = 1; k <= 5; k++) begin
      prev = (k == 1) ? fetch_valid : mv[k-1];
      if (!stall[k-1]) nv[k] = prev;
      else if (!stall[k]) nv[k] = 0;
      else nv[k] = mv[k];
    end
    if (flush) begin
      nv[1] = 0; nv[2] = 0; nv[3] = 0;
    end
    mret = mv[5] && !stall[5];
    if (mret) mcnt = (mcnt + 1) % MOD;
    c = $countones(stall);
    legal = (1 << c) - 1;
    if (int'(stall) != legal) merr = 1;
    if (stall[0]) begin
      if (run < MAXS) run++;
      mcyc = (mcyc + 1) % MOD;
    end else begin
      run = 0;
    end
    if (run == MAXS) mto = 1;
    if (exp_bub() != 0) mbub = (mbub + 1) % MOD;
    for (int k = 1; k <= 5; k++) mv[k] = nv[k];
  endtask

  task automatic check_comb();
    chk("pc_en", 32'(pc_en), 32'(!stall[0]));
    chk("reg_adv", 32'(reg_adv), 32'(exp_adv()));
    chk("reg_bubble", 32'(reg_bubble), 32'(exp_bub()));
  endtask

  task automatic check_regs();
    chk("stage_valid", 32'(stage_valid), 32'(mvec()));
    chk("retire", 32'(retire), 32'(mret));
    chk("retire_cnt", 32'(retire_cnt), 32'(mcnt));
    chk("stall_err", 32'(stall_err), 32'(merr));
    chk("stall_timeout", 32'(stall_timeout), 32'(mto));
`ifdef STALL_PERF_CNT_EN
    chk("stall_cyc_cnt", 32'(stall_cyc_cnt), 32'(mcyc));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(mbub));
`endif
  endtask

  task automatic cycle(input logic [5:0] s, input logic f, input logic fv);
    stall = s;
    flush = f;
    fetch_valid = fv;
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  // Async reset applied and released between clock edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic fill();
    repeat (6) cycle(6'b000000, 1'b0, 1'b1);
  endtask

  initial begin
    int r, c, t;
    logic [5:0] s;
    reset_n = 1'b0;
    stall = '0;
    flush = 1'b0;
    fetch_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    fill();
    chk("t1_full", 32'(stage_valid), 32'h1f);
    chk("t1_retire", 32'(retire), 32'd1);
    chk("t1_cnt", 32'(retire_cnt), 32'd1);

    cycle(6'b000111, 1'b0, 1'b1);
    chk("t2_bubble", 32'(stage_valid), 32'h1b);
    cycle(6'b000111, 1'b0, 1'b1);
    cycle(6'b000111, 1'b0, 1'b1);
    cycle(6'b000000, 1'b0, 1'b1);

    do_reset();
    fill();
    cycle(6'b000011, 1'b1, 1'b1);
    chk("t3_flush", 32'(stage_valid), 32'h18);
    chk("t3_err", 32'(stall_err), 32'd0);

    cycle(6'b000101, 1'b0, 1'b1);
    chk("t4_err", 32'(stall_err), 32'd1);
    cycle(6'b000000, 1'b0, 1'b1);
    chk("t4_sticky", 32'(stall_err), 32'd1);

    do_reset();
    repeat (3) cycle(6'b000001, 1'b0, 1'b1);
    cycle(6'b000000, 1'b0, 1'b1);
    chk("t5_short", 32'(stall_timeout), 32'd0);
    repeat (4) cycle(6'b000001, 1'b0, 1'b1);
    chk("t5_to", 32'(stall_timeout), 32'd1);
    cycle(6'b000000, 1'b0, 1'b1);
    chk("t5_sticky", 32'(stall_timeout), 32'd1);

    repeat (3) cycle(6'b000011, 1'b0, 1'b1);
    do_reset();
    chk("t6_valid", 32'(stage_valid), 32'd0);
    repeat (8) cycle(6'b000001, 1'b0, 1'b1);
    fill();

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        s = 6'($urandom);
      end else begin
        c = (r < 50) ? 0 : $urandom_range(1, 6);
        t = (1 << c) - 1;
        s = 6'(t);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(s, 1'($urandom_range(0, 9) == 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
